// File: rtl/vend_session_arbiter_if.sv
// Coin-slot side bundle of the vending session arbiter.
// master = front panel / vending FSM, slave = arbiter.
interface vend_session_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [2*N-1:0] coin_in;
  logic           vend_drop;
  logic [1:0]     coin_out;
  logic [N-1:0]   grant;
  logic [N-1:0]   drop_out;
  logic           timeout_abort;
  logic           busy;

  modport master (
    output req, coin_in, vend_drop,
    input  coin_out, grant, drop_out,
    input  timeout_abort, busy
  );

  modport slave (
    input  req, coin_in, vend_drop,
    output coin_out, grant, drop_out,
    output timeout_abort, busy
  );
endinterface

// File: rtl/vend_session_arbiter.sv
// Round-robin session arbiter sharing one vending FSM
// among N coin slots; releases on drop, withdraw, timeout.
module vend_session_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 15
) (
  input logic clock,
  input logic reset,
  vend_session_arbiter_if.slave arb
);
  localparam int LW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  drop_q, drop_d;
  logic [1:0]    coin_q, coin_d;
  logic          tmo_q, tmo_d;
  logic          busy_q, busy_d;

  logic [LW-1:0] win;
  logic          found;
  logic [1:0]    own_coin;
  logic          own_req;

  assign own_coin = arb.coin_in[2*last_q +: 2];
  assign own_req  = arb.req[last_q];

  // first requester after the last owner, wrapping
  always_comb begin
    win   = last_q;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && arb.req[(int'(last_q) + k) % N]) begin
        found = 1'b1;
        win   = LW'((int'(last_q) + k) % N);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    drop_d  = '0;
    coin_d  = 2'b00;
    tmo_d   = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ACTIVE;
          last_d  = win;
          cnt_d   = '0;
          grant_d = {{(N-1){1'b0}}, 1'b1} << win;
          busy_d  = 1'b1;
        end
      end
      ACTIVE: begin
        busy_d = 1'b1;
        cnt_d  = '0;
        if (arb.vend_drop) begin
          state_d = RELEASE;
          drop_d  = grant_q;
        end else if (!own_req) begin
          state_d = RELEASE;
        end else if (own_coin == 2'b00 &&
                     cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = RELEASE;
          tmo_d   = 1'b1;
        end else begin
          grant_d = grant_q;
          coin_d  = own_coin;
          if (own_coin == 2'b00) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LW'(N - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      drop_q  <= '0;
      coin_q  <= 2'b00;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      drop_q  <= drop_d;
      coin_q  <= coin_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
    end
  end

  assign arb.grant         = grant_q;
  assign arb.drop_out      = drop_q;
  assign arb.coin_out      = coin_q;
  assign arb.timeout_abort = tmo_q;
  assign arb.busy          = busy_q;
endmodule

// File: tb/tb_vend_session_arbiter.sv
// Directed bench for vend_session_arbiter (N=4,
// TIMEOUT=15) with hand-computed expectations.
module tb_vend_session_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  vend_session_arbiter_if #(.N(4)) arb ();

  vend_session_arbiter #(
    .N(4),
    .TIMEOUT(15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .arb(arb)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic outs(input string tag,
                      input logic [3:0] g,
                      input logic [1:0] c,
                      input logic [3:0] d,
                      input logic t,
                      input logic b);
    check({tag, ".grant"}, 32'(arb.grant), 32'(g));
    check({tag, ".coin"}, 32'(arb.coin_out), 32'(c));
    check({tag, ".drop"}, 32'(arb.drop_out), 32'(d));
    check({tag, ".tmo"}, 32'(arb.timeout_abort), 32'(t));
    check({tag, ".busy"}, 32'(arb.busy), 32'(b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq [4];
    int first;
    int pulses;
    seq[0] = 4'b0010;
    seq[1] = 4'b0100;
    seq[2] = 4'b1000;
    seq[3] = 4'b0001;

    arb.req       = '0;
    arb.coin_in   = '0;
    arb.vend_drop = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    outs("rst", 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0);

    // grant latency and coin forwarding
    arb.req     = 4'b0001;
    arb.coin_in = 8'h01;
    step();
    outs("grant0", 4'b0001, 2'b00, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      outs("fwd", 4'b0001, 2'b01, 4'b0000, 1'b0, 1'b1);
    end

    // drop release with pending requesters
    arb.coin_in   = 8'h02;
    arb.vend_drop = 1'b1;
    arb.req       = 4'b0111;
    step();
    outs("drop_t1", 4'b0000, 2'b00, 4'b0001, 1'b0, 1'b1);
    arb.vend_drop = 1'b0;
    arb.coin_in   = 8'h00;
    arb.req       = 4'b0110;
    step();
    outs("drop_t2", 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0);
    step();
    outs("drop_t3", 4'b0010, 2'b00, 4'b0000, 1'b0, 1'b1);

    // round robin with vend_drop held high
    arb.req       = 4'b1111;
    arb.vend_drop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rr.drop", 32'(arb.drop_out), 32'(seq[k]));
      check("rr.gnt0", 32'(arb.grant), 32'd0);
      step();
      check("rr.idle_drop", 32'(arb.drop_out), 32'd0);
      step();
      check("rr.grant", 32'(arb.grant), 32'(seq[k+1]));
      check("rr.nodrop", 32'(arb.drop_out), 32'd0);
    end

    // drop and req fall together: drop wins
    arb.req = 4'b0000;
    step();
    outs("dropwin", 4'b0000, 2'b00, 4'b0001, 1'b0, 1'b1);
    arb.vend_drop = 1'b0;
    step();
    outs("dropwin2", 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0);

    // idle timeout, no coins
    arb.req = 4'b0010;
    step();
    check("to.grant", 32'(arb.grant), 32'b0010);
    pulses = 0;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (arb.timeout_abort) pulses++;
    end
    check("to.early", 32'(pulses), 32'd0);
    check("to.held", 32'(arb.grant), 32'b0010);
    step();
    outs("to.pulse", 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b1);
    step();
    outs("to.after", 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0);
    step();
    check("to.regrant", 32'(arb.grant), 32'b0010);

    // one coin on the 10th active cycle delays it by 10
    first  = 0;
    pulses = 0;
    for (int i = 1; i <= 26; i++) begin
      arb.coin_in = (i == 10) ? 8'h04 : 8'h00;
      step();
      if (i == 10)
        check("to.coin", 32'(arb.coin_out), 32'd1);
      if (arb.timeout_abort) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("to.delay", 32'(first), 32'd25);
    check("to.once", 32'(pulses), 32'd1);
    arb.req = 4'b0000;
    step();
    check("to.idle", 32'(arb.busy), 32'd0);

    // non-owner coins never forwarded; withdraw
    arb.req     = 4'b0001;
    arb.coin_in = 8'hFC;
    step();
    check("no.grant", 32'(arb.grant), 32'b0001);
    for (int i = 0; i < 2; i++) begin
      step();
      check("no.coin", 32'(arb.coin_out), 32'd0);
    end
    arb.req     = 4'b0000;
    arb.coin_in = 8'hFF;
    step();
    outs("wd", 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1);
    arb.coin_in   = 8'h00;
    arb.vend_drop = 1'b1;
    step();
    check("idle.drop1", 32'(arb.drop_out), 32'd0);
    step();
    check("idle.drop2", 32'(arb.drop_out), 32'd0);
    check("idle.busy", 32'(arb.busy), 32'd0);
    arb.vend_drop = 1'b0;

    // reset mid-session
    arb.req = 4'b1000;
    step();
    check("rs.grant", 32'(arb.grant), 32'b1000);
    arb.coin_in = 8'h40;
    step();
    check("rs.coin", 32'(arb.coin_out), 32'd1);
    reset         = 1'b1;
    arb.vend_drop = 1'b1;
    step();
    outs("rs.mid", 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0);
    reset         = 1'b0;
    arb.vend_drop = 1'b0;
    arb.coin_in   = 8'h00;
    arb.req       = 4'b0110;
    step();
    check("rs.scan", 32'(arb.grant), 32'b0010);
    arb.req = 4'b0000;
    step();
    step();
    reset = 1'b1;
    step();
    reset   = 1'b0;
    arb.req = 4'b0100;
    step();
    check("rs.grant2", 32'(arb.grant), 32'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
